// File: rtl/vga_buffer_reader.sv
// VGA read side for the three per-channel frame buffers. The h/v counters form the state and
// drive the shared read address; optional colour bars are built in when TEST_PATTERN_EN is defined.
module vga_buffer_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic [10:0] data_out_x,
    output logic [10:0] data_out_y,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    input  logic        test_pattern,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        pix_en_q, pix_en_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic        vclk_q, vclk_d, fs_q, fs_d;
    logic        visible, visible_next;
    logic [7:0]  pix_r, pix_g, pix_b;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
            vclk_q   <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            pix_en_q <= pix_en_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            vclk_q   <= vclk_d;
            fs_q     <= fs_d;
        end
    end

    // Counters advance on pixel ticks; the address register follows the next counter value.
    always_comb begin
        pix_en_d = ~pix_en_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        if (pix_en_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        visible_next = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        x_d = visible_next ? {1'b0, h_cnt_d} : '0;
        y_d = visible_next ? {1'b0, v_cnt_d} : '0;
    end

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;
    logic [2:0]  bar;
    logic [23:0] bar_rgb;

    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt_q >= 10'(i * BAR_W)) bar = 3'(i);
        end
        case (bar)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        {pix_r, pix_g, pix_b} = {red_in, green_in, blue_in};
        if (test_pattern) {pix_r, pix_g, pix_b} = bar_rgb;
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;

    always_comb begin
        {pix_r, pix_g, pix_b} = {red_in, green_in, blue_in};
    end
`endif

    // Output stage samples the current counters, so pins lag the counters by one pixel.
    always_comb begin
        visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        if (pix_en_q) begin
            r_d     = visible ? pix_r : '0;
            g_d     = visible ? pix_g : '0;
            b_d     = visible ? pix_b : '0;
            hs_d    = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
            vs_d    = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
            blank_d = visible;
        end
        fs_d   = pix_en_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        vclk_d = ~pix_en_d;
    end

    assign data_out_x  = x_q;
    assign data_out_y  = y_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vclk_q;
    assign frame_start = fs_q;
endmodule

// File: doc/vga_buffer_reader.md
# vga_buffer_reader

Read side of the 640x480 per-channel frame buffers. Generates 640x480@60 Hz VGA timing from `CLOCK_50` and drives a shared read address (x, y) to the red, green and blue buffers. It captures their 8-bit pixel data one clock later and drives the registered VGA DAC and sync pins. The block sits between the three channel buffers and the board VGA connector; camera-side logic owns the write ports.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, `H_SYNC`, 96, `H_BACK`, 48: horizontal porch and sync widths in pixels (total 800)
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, `V_SYNC`, 2, `V_BACK`, 33: vertical widths in lines (total 525)

Ports:
- `CLOCK_50` in 1: system clock, 50 MHz
- `reset` in 1: asynchronous, active-high
- `data_out_x` out 11: buffer read column
- `data_out_y` out 11: buffer read row
- `red_in`, `green_in`, `blue_in` in 8 each: buffer read data, valid one `CLOCK_50` cycle after the address
- `test_pattern` in 1: select colour bars (honoured only with `TEST_PATTERN_EN`)
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: pixel colour
- `VGA_HS`, `VGA_VS` out 1: syncs, active-low
- `VGA_BLANK_N` out 1: low outside the visible area
- `VGA_SYNC_N` out 1: constant 0
- `VGA_CLK` out 1: 25 MHz pixel clock to the DAC
- `frame_start` out 1: one-cycle pulse at the start of each frame

## Operation
- `pix_en` register:
  - Reset value 0. Toggles every `CLOCK_50` cycle.
  - Cycles with `pix_en`=1 are pixel ticks at 25 MHz.
- `h_cnt` (10 bit, 0..799) and `v_cnt` (10 bit, 0..524):
  - Advance only on pixel ticks.
  - `h_cnt` wraps 799 to 0 and increments `v_cnt`. `v_cnt` wraps 524 to 0.
  - No other state exists; the counters act as the state machine.
- Visible region: `h_cnt`<640 and `v_cnt`<480.
- Read address:
  - `data_out_x` = `h_cnt` and `data_out_y` = `v_cnt` when visible; otherwise both 0.
  - Both are zero-extended to 11 bits and registered alongside the counters.
  - The address therefore never exceeds 639/479.
- Sync decode:
  - `VGA_HS` is low for `h_cnt` in 656..751.
  - `VGA_VS` is low for `v_cnt` in 490..491.
- Output register, loaded on each pixel tick from the current counter and address values:
  - `VGA_R/G/B` take `red/green/blue_in` when visible, else 0.
  - `VGA_BLANK_N` = visible.
  - `VGA_HS` and `VGA_VS` take their decoded values.
- `frame_start`: pulses 1 for exactly one `CLOCK_50` cycle on the tick where the counters wrap to (0,0).
- `VGA_CLK` = ~`pix_en` (registered), so the DAC sees its rising edge mid-pixel.
- Reset values:
  - `pix_en`, counters, `data_out_x/y`: 0
  - `VGA_R/G/B`: 0
  - `VGA_HS`, `VGA_VS`: 1
  - `VGA_BLANK_N`: 0
  - `VGA_CLK`: 1
  - `frame_start`: 0
- Reset asserted mid-line returns every output to its reset value asynchronously. Timing restarts at (0,0) on the second `CLOCK_50` edge after release.

## Timing
- The address is stable for 2 `CLOCK_50` cycles:
  - Edge 1: the buffer registers its data.
  - Edge 2 (pixel tick): this block captures that data.
  - No combinational path runs from `*_in` to any output.
- Pixel (x,y) appears on the VGA pins one pixel period (2 `CLOCK_50` cycles) after its counter value. Sync and blank share the same register stage, so all outputs are aligned.
- Line period: 1600 `CLOCK_50` cycles. Frame period: 840000 cycles.

## Configuration
- `TEST_PATTERN_EN` defined:
  - When `test_pattern`=1, the visible RGB is replaced by 8 vertical bars, each 80 pixels wide, selected by `h_cnt[9:7]`-equivalent division by 80.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Channels are 0xFF/0x00. The buffer address is still driven.
- Undefined: `test_pattern` is ignored and the bar logic is absent.

## Test plan
- Reset held 5 cycles, then released:
  - All outputs hold their reset values during reset.
  - The first pixel tick is at the second edge after release.
  - `frame_start`=1 for one cycle at the wrap 840000 cycles later.
- Full frame, counting `CLOCK_50` cycles:
  - `VGA_HS` low for 192 cycles per line, period 1600.
  - `VGA_VS` low for 3200 cycles, period 840000.
  - `VGA_BLANK_N` high for 1280 cycles per visible line.
- Buffer model returns `red_in`=x[7:0], `blue_in`=y[7:0] one cycle after the address:
  - `VGA_R` matches x and `VGA_B` matches y on every visible pixel.
  - At (639,479), outputs are 0x7F/0xDF.
- Non-visible region: `data_out_x`=`data_out_y`=0 and `VGA_R/G/B`=0 for `h_cnt`=640..799, even with inputs driven 0xFF.
- Reset pulsed at `h_cnt`=300, `v_cnt`=200: outputs clear immediately and timing restarts at (0,0) with no partial line.
- With `TEST_PATTERN_EN` and `test_pattern`=1: pixel x=85 outputs R=0xFF, G=0xFF, B=0x00 (yellow); x=600 outputs 0/0/0.
